// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory, one 15-bit word per two bytes.
// Optional trailing XOR checksum is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [14:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_DONE
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [14:0] wdata_q, wdata_d;
  logic [8:0]  remain_q, remain_d;
  logic        xfer;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]  acc_q, acc_d;
`endif

  assign xfer     = byte_valid && byte_ready;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    remain_d   = remain_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    acc_d      = acc_q;
`endif
    byte_ready = 1'b0;
    im_we      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEN;
          addr_d  = 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          acc_d   = 8'd0;
`endif
        end
      end
      S_LEN: begin
        byte_ready = 1'b1;
        if (xfer) begin
          // A length byte of zero encodes a full 256-instruction image.
          remain_d = (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          acc_d    = acc_q ^ byte_data;
`endif
          state_d  = S_HI;
        end
      end
      S_HI: begin
        byte_ready = 1'b1;
        if (xfer) begin
          wdata_d[14:8] = byte_data[6:0];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          acc_d         = acc_q ^ byte_data;
`endif
          state_d       = S_LO;
        end
      end
      S_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          wdata_d[7:0] = byte_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          acc_d        = acc_q ^ byte_data;
`endif
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        im_we    = 1'b1;
        addr_d   = addr_q + 8'd1;
        remain_d = remain_q - 9'd1;
        if (remain_q == 9'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_HI;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (xfer) begin
          state_d = (byte_data == acc_q) ? S_DONE : S_ERR;
        end
      end
      S_ERR: begin
        err = 1'b1;
        if (start) begin
          state_d = S_LEN;
          addr_d  = 8'd0;
          acc_d   = 8'd0;
        end
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) begin
          state_d = S_LEN;
          addr_d  = 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          acc_d   = 8'd0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 8'd0;
      wdata_q  <= 15'd0;
      remain_q <= 9'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      acc_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      remain_q <= remain_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      acc_q    <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a queue model of expected writes checked on every im_we pulse.
module tb_program_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [14:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  program_loader dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected writes as {addr, word}, derived from the byte stream alone.
  logic [22:0] exp_q[$];
  int          cap_n = 0;
  logic [7:0]  cap_addr[0:511];
  logic [14:0] cap_data[0:511];
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    logic [22:0] e;
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (im_we) begin
        chk("we_single_cycle", prev_we, 0);
        chk("we_not_ready", byte_ready, 0);
        chk("we_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", im_addr, e[22:15]);
          chk("wr_data", im_wdata, e[14:0]);
        end
        if (cap_n < 512) begin
          cap_addr[cap_n] = im_addr;
          cap_data[cap_n] = im_wdata;
        end
        cap_n++;
      end
      chk("hold_vs_done", cpu_hold, !done);
      prev_we = im_we;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    while (!byte_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("byte_ready_timeout", k < 50, 1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(done || err) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("finish_timeout", k < 200, 1);
  endtask

  // Model: N instructions follow the length byte; word i = {hi[6:0], lo} at address i mod 256.
  task automatic load(input logic [7:0] b[$], input int gap);
    int n;
    n = (b[0] == 8'd0) ? 256 : int'(b[0]);
    for (int i = 0; i < n; i++)
      exp_q.push_back({8'(i), b[1 + 2*i][6:0], b[2 + 2*i]});
    cap_n = 0;
    pulse_start();
    foreach (b[k]) send_byte(b[k], gap);
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] b[$]);
    logic [7:0] x;
    x = 8'd0;
    foreach (b[k]) x = x ^ b[k];
    return x;
  endfunction

  task automatic load_auto(input logic [7:0] b[$], input int gap);
    logic [7:0] q[$];
    q = b;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    q.push_back(xsum(b));
`endif
    load(q, gap);
  endtask

  initial begin
    logic [7:0] s[$];

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_we", im_we, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_addr", im_addr, 0);

    // Basic load, valid held high
    s = '{8'h02, 8'h05, 8'h0A, 8'h86, 8'h33};
    load_auto(s, 0);
    wait_end();
    chk("basic_done", done, 1);
    chk("basic_hold", cpu_hold, 0);
    chk("basic_err", err, 0);
    chk("basic_count", cap_n, 2);
    chk("basic_a0", cap_addr[0], 8'h00);
    chk("basic_d0", cap_data[0], 15'h050A);
    chk("basic_a1", cap_addr[1], 8'h01);
    chk("basic_d1", cap_data[1], 15'h0633);
    chk("basic_drained", exp_q.size(), 0);

    // Same stream with 3-cycle gaps
    load_auto(s, 3);
    wait_end();
    chk("gap_done", done, 1);
    chk("gap_count", cap_n, 2);
    chk("gap_d1", cap_data[1], 15'h0633);
    chk("gap_drained", exp_q.size(), 0);

    // LEN=0 means 256 instructions; addresses 0..255
    s = '{8'h00};
    for (int i = 0; i < 256; i++) begin
      s.push_back(8'(i) ^ 8'h80);
      s.push_back(~8'(i));
    end
    load_auto(s, 0);
    wait_end();
    chk("wrap_done", done, 1);
    chk("wrap_count", cap_n, 256);
    chk("wrap_last_addr", cap_addr[255], 8'hFF);
    chk("wrap_last_data", cap_data[255], 15'h7F00);
    chk("wrap_drained", exp_q.size(), 0);

    // Reset after the first HI byte: session abandoned
    cap_n = 0;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_writes", cap_n, 0);
    chk("midrst_ready", byte_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hold", cpu_hold, 1);
    chk("midrst_addr", im_addr, 0);
    chk("midrst_wdata", im_wdata, 0);

    // start during LO is ignored: the next byte is still taken as LO
    exp_q.push_back({8'h00, 15'h1234});
    cap_n = 0;
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    pulse_start();
    send_byte(8'h34, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h27, 0);
`endif
    wait_end();
    chk("lostart_done", done, 1);
    chk("lostart_count", cap_n, 1);
    chk("lostart_d0", cap_data[0], 15'h1234);

    // Fresh 1-instruction session writes address 0
    s = '{8'h01, 8'hAB, 8'hCD};
    load_auto(s, 1);
    wait_end();
    chk("restart_done", done, 1);
    chk("restart_a0", cap_addr[0], 8'h00);
    chk("restart_d0", cap_data[0], 15'h2BCD);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    s = '{8'h01, 8'h12, 8'h34};
    chk("model_xsum", xsum(s), 8'h27);
    s.push_back(8'h27);
    load(s, 0);
    wait_end();
    chk("ck_good_done", done, 1);
    chk("ck_good_err", err, 0);
    s = '{8'h01, 8'h12, 8'h34, 8'h00};
    load(s, 2);
    wait_end();
    chk("ck_bad_err", err, 1);
    chk("ck_bad_done", done, 0);
    chk("ck_bad_hold", cpu_hold, 1);
    chk("ck_bad_a0", cap_addr[0], 8'h00);
    chk("ck_bad_d0", cap_data[0], 15'h1234);
`else
    chk("nock_err_tied", err, 0);
`endif

    chk("final_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. Ports: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 start  input  1  In IDLE, DONE or ERR: begins a new load session; ignored in all other states.
REQ-003 byte_valid  input  1  Upstream byte stream has a byte present.
REQ-004 byte_data  input  8  Stream byte; sampled only on an accepted transfer.
REQ-005 byte_ready  output  1  Loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
REQ-006 im_we  output  1  Instruction-memory write strobe, one cycle per instruction.
REQ-007 im_addr  output  8  Instruction-memory write address.
REQ-008 im_wdata  output  15  Instruction word: opcode in [14:8], literal in [7:0].
REQ-009 cpu_hold  output  1  Holds the computer's PC and registers while the program is not valid.
REQ-010 done  output  1  Load completed successfully.
REQ-011 err  output  1  Load failed on a checksum mismatch (only when CHECKSUM_EN is defined).

Function
REQ-012 States: IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR.
REQ-013 Transitions:
- IDLE, DONE or ERR with start=1 -> LEN.
- LEN, on a transfer -> HI.
- HI, on a transfer -> LO.
- LO, on a transfer -> WRITE.
- WRITE -> HI if more instructions remain; otherwise CHK (CHECKSUM_EN) or DONE.
- CHK, on a transfer -> DONE on a match, ERR on a mismatch.
REQ-014 The LEN byte gives the instruction count N; the value 0 means N=256.
REQ-015 byte_ready SHALL be 1 only in LEN, HI, LO and CHK, and is not conditioned on byte_valid.
REQ-016 The HI byte is latched and loaded into im_wdata[14:8] from bits [6:0]; bit 7 is ignored.
REQ-017 The LO byte is latched into im_wdata[7:0].
REQ-018 In WRITE, im_we=1 for exactly one cycle, with stable im_addr and im_wdata.
REQ-019 im_we SHALL be 0 in every other state.
REQ-020 Entering LEN clears im_addr to 0.
REQ-021 im_addr increments by 1 on the cycle after each WRITE, wrapping 255->0. For N=256, the last write goes to address 255.
REQ-022 A 9-bit remaining counter is loaded with N in LEN and decrements in each WRITE; the last instruction is detected when the counter equals 1.
REQ-023 cpu_hold SHALL be 1 in every state except DONE; done=1 only in DONE; err=1 only in ERR.
REQ-024 Bytes are never dropped or duplicated. A stalled byte_valid leaves the state, latches and counter unchanged.
REQ-025 start asserted in LEN through CHK SHALL be ignored and SHALL NOT restart the session.

Reset
REQ-026 rst=1 at a rising clk edge forces, on that edge:
- state IDLE;
- im_addr=0, im_wdata=0, the remaining counter=0, the checksum accumulator=0;
- im_we=0, byte_ready=0, done=0, err=0, cpu_hold=1.
REQ-027 rst takes priority over start and byte transfers.
REQ-028 rst mid-session abandons the session; no further im_we pulses occur until a new start.

Configuration
REQ-029 Macro PROGRAM_LOADER_CHECKSUM_EN.
REQ-030 With the macro defined:
- an 8-bit accumulator is cleared on entering LEN;
- every accepted LEN, HI and LO byte is XORed into it (full 8 bits, including the HI bit 7);
- after the last WRITE the loader enters CHK, accepts one byte, and goes to DONE if the byte equals the accumulator, otherwise to ERR.
- Instructions already written are not rolled back on a mismatch.
REQ-031 Without the macro, CHK, ERR and the accumulator SHALL NOT exist. err is tied to 0, and the last WRITE goes directly to DONE.

Verification
REQ-032 Reset: hold rst for 2 cycles -> im_we=0, byte_ready=0, done=0, err=0, cpu_hold=1, im_addr=0.
REQ-033 Basic load: start, then bytes 02, 05, 0A, 86, 33 with valid held high ->
- writes (addr 0, 0x050A) and (addr 1, 0x0633);
- each im_we pulse is one cycle;
- then done=1 and cpu_hold=0.
REQ-034 Backpressure gaps: the same stream with byte_valid dropped for 3 cycles between every byte -> identical writes, with no extra im_we pulses.
REQ-035 Wrap-around: LEN=00 followed by 512 bytes -> 256 writes to addresses 0..255, the last at 255, then done (CHECKSUM_EN undefined).
REQ-036 Checksum (CHECKSUM_EN defined):
- stream 01, 12, 34, then checksum 27 -> done=1.
- The same stream with checksum 00 -> err=1, cpu_hold=1, and word 0x1234 written at address 0.
REQ-037 Reset mid-session and restart:
- assert rst after the HI byte of instruction 1 -> no im_we pulse, state IDLE.
- start asserted during LO has no effect.
- after reset, a new start plus a 1-instruction stream writes address 0.
